pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed decode→execute pipeline register: one generic pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer, synchronous flush with bubble zeroing, and saturating stall/bubble performance counters.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM). Replaces ad-hoc 2-bit enable encodings with explicit handshake plus flush.

Parameters:
- DATA_W, 32, width of datapath payload (immediate, operands, PC, instruction, concatenated by the instantiator).
- CTRL_W, 16, width of control payload (ALU select, write-back enable, mem write, rd, and so on). Forced to zero whenever the stage holds a bubble.
- SKID, 1. 1 = two-entry skid buffer with registered in_ready. 0 = single register with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- cpu_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries (branch redirect, hazard bubble)
- clr_cnt  in  1  synchronous clear of both performance counters
- in_valid  in  1  upstream has a valid entry
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream datapath payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  stage presents a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  registered datapath payload
- out_ctrl  out  CTRL_W  registered control payload
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating

Behaviour:
- Event definitions: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - Skid entry invalidated and zeroed.
  - stall_cnt=0, bubble_cnt=0.
  - in_ready=1 when SKID=1.
- State machine, SKID=1. States: EMPTY (occ 0), FULL (occ 1, main reg only), SKID (occ 2, main + skid). in_ready = (state != SKID), taken from a register, no combinational path from out_ready.
  - EMPTY: accept → FULL, main ← in. Otherwise stay.
  - FULL, accept & emit → FULL, main ← in.
  - FULL, accept & !emit → SKID, skid ← in, main unchanged.
  - FULL, !accept & emit → EMPTY, main zeroed.
  - FULL, neither event → hold.
  - SKID: no accept possible. emit → FULL, main ← skid, skid zeroed. Otherwise hold both.
- SKID=0:
  - States EMPTY and FULL only. in_ready = !out_valid | out_ready (combinational).
  - Transitions are the same as FULL/EMPTY above. occupancy never exceeds 1.
- Ordering: first-in first-out, no reordering or duplication. Latency is one cycle from accept to out_valid when the stage is empty.
- Bubble zeroing: whenever an entry is invalid, its data and ctrl registers are 0, so out_valid=0 implies out_ctrl=0 and out_data=0.
- Flush (priority over all handshake activity):
  - Next cycle: state EMPTY, out_valid=0, all payload registers zeroed.
  - A same-cycle accept is dropped. A same-cycle emit still counts as taken by downstream.
  - in_ready=1 the cycle after flush.
- Counters:
  - Evaluated each cycle on registered out_valid and on out_ready. Saturate at 2^CNT_W−1 with no wrap.
  - clr_cnt has priority over increment; the counter reads 0 the next cycle.
  - Flush does not clear the counters.
- Simultaneous flush and clr_cnt: both take effect.

Test Plan:
- Reset, then stream 4 entries with out_ready=1 and in_data=1..4, ctrl=0xA5A5 → out_data 1,2,3,4 on consecutive cycles, each one cycle after accept; occupancy ≤1; stall_cnt=0.
- SKID=1: hold out_ready=0 and offer 3 entries (0x11,0x22,0x33) → 0x11 and 0x22 accepted; in_ready=0 at occupancy=2; 0x33 held upstream. Release out_ready → order 0x11,0x22,0x33; stall_cnt equals the number of back-pressure cycles.
- Flush asserted with occupancy=2 and in_valid=1 (data 0x44) → next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; 0x44 never appears at the output; in_ready=1.
- Async reset asserted mid-cycle while in SKID → outputs zero immediately, before the next clock edge; counters 0; after deassert, the first new entry emerges correctly.
- CNT_W=4, idle for 20 cycles → bubble_cnt saturates at 15. Pulse clr_cnt → 0 next cycle, then increments again.
- SKID=0, out_ready toggling 1,0,1,0 with in_valid=1 → in_ready follows !out_valid|out_ready combinationally; no entry lost or duplicated over 8 entries.

Source files
------------

// File: rtl/pipe_stage_elastic_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic_if
// Purpose  : upstream/downstream valid-ready handshake bundle for one stage
// Revision : 1.0
// ============================================================================
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // slave = the pipeline stage itself, master = the surrounding pipeline
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic
// Purpose  : generic valid/ready pipeline register with optional skid entry,
//            flush with bubble zeroing and saturating stall/bubble counters
// Revision : 1.0
// ============================================================================
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  wire logic           cpu_clk,
  input  wire logic           reset,
  input  wire logic           flush,
  input  wire logic           clr_cnt,
  pipe_stage_elastic_if.slave bus,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);
  localparam int               c_pay_w   = DATA_W + CTRL_W;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_pay_w-1:0] r_main;
  logic [c_pay_w-1:0] w_main_nxt;
  logic [c_pay_w-1:0] r_skid;
  logic [c_pay_w-1:0] w_skid_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_bubble_cnt;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_emit;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_emit      = w_out_valid & bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid_ready
      // Registered ready breaks the out_ready -> in_ready timing path
      logic r_in_ready;
      always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) r_in_ready <= 1'b1;
        else       r_in_ready <= (w_state_nxt != ST_SKID);
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_comb_ready
      assign w_in_ready = !w_out_valid || bus.out_ready;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = {bus.in_data, bus.in_ctrl};
          end
        end
        ST_FULL: begin
          case ({w_accept, w_emit})
            2'b11: w_main_nxt = {bus.in_data, bus.in_ctrl};
            2'b10: begin
              w_state_nxt = ST_SKID;
              w_skid_nxt  = {bus.in_data, bus.in_ctrl};
            end
            2'b01: begin
              w_state_nxt = ST_EMPTY;
              w_main_nxt  = '0;
            end
            default: ;
          endcase
        end
        ST_SKID: begin
          if (w_emit) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Counters observe the registered out_valid; flush deliberately leaves them alone
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready && (r_stall_cnt != c_cnt_max))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!w_out_valid && (r_bubble_cnt != c_cnt_max))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  always_comb begin
    case (r_state)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign bus.in_ready                 = w_in_ready;
  assign bus.out_valid                = w_out_valid;
  assign {bus.out_data, bus.out_ctrl} = r_main;
  assign stall_cnt                    = r_stall_cnt;
  assign bubble_cnt                   = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_elastic
// Purpose  : queue-model bench for the skid (SKID=1) and pass (SKID=0) builds
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_elastic;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PW = DW + CW;

  logic          cpu_clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          clr_cnt;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  always #5 cpu_clk = ~cpu_clk;

  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus_s ();
  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus_p ();

  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.in_ctrl   = in_ctrl;
  assign bus_s.out_ready = out_ready;
  assign bus_p.in_valid  = in_valid;
  assign bus_p.in_data   = in_data;
  assign bus_p.in_ctrl   = in_ctrl;
  assign bus_p.out_ready = out_ready;

  logic [1:0]  occ_s, occ_p;
  logic [3:0]  stall_s, bubble_s;
  logic [15:0] stall_p, bubble_p;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_skid (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .flush      (flush),
    .clr_cnt    (clr_cnt),
    .bus        (bus_s),
    .occupancy  (occ_s),
    .stall_cnt  (stall_s),
    .bubble_cnt (bubble_s)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_pass (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .flush      (flush),
    .clr_cnt    (clr_cnt),
    .bus        (bus_p),
    .occupancy  (occ_p),
    .stall_cnt  (stall_p),
    .bubble_cnt (bubble_p)
  );

  // Observed view of whichever build is under test
  logic          sel;
  logic          o_rdy, o_v;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_occ;
  logic [15:0]   o_stall, o_bubble;

  always_comb begin
    o_rdy    = sel ? bus_p.in_ready  : bus_s.in_ready;
    o_v      = sel ? bus_p.out_valid : bus_s.out_valid;
    o_data   = sel ? bus_p.out_data  : bus_s.out_data;
    o_ctrl   = sel ? bus_p.out_ctrl  : bus_s.out_ctrl;
    o_occ    = sel ? occ_p           : occ_s;
    o_stall  = sel ? stall_p         : {12'd0, stall_s};
    o_bubble = sel ? bubble_p        : {12'd0, bubble_s};
  end

  // Reference model: the stage is a FIFO of capacity 2 (skid) or 1 (pass)
  logic [PW-1:0] mq[$];
  logic [PW-1:0] pend[$];
  int unsigned   m_stall, m_bubble, cnt_max;
  bit            m_skid, send_en;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    if (m_skid) return (mq.size() < 2);
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic check_outputs(string ph);
    logic [PW-1:0] front;
    front = (mq.size() > 0) ? mq[0] : '0;
    chk({ph, ".in_ready"},  64'(o_rdy),    64'(exp_ready()));
    chk({ph, ".out_valid"}, 64'(o_v),      64'(mq.size() > 0));
    chk({ph, ".out_data"},  64'(o_data),   64'(front[PW-1:CW]));
    chk({ph, ".out_ctrl"},  64'(o_ctrl),   64'(front[CW-1:0]));
    chk({ph, ".occupancy"}, 64'(o_occ),    64'(mq.size()));
    chk({ph, ".stall_cnt"}, 64'(o_stall),  64'(m_stall));
    chk({ph, ".bubble_cnt"},64'(o_bubble), 64'(m_bubble));
  endtask

  // One clock: drive at edge+1, check at negedge, advance model at posedge
  task automatic cycle(string ph);
    bit acc, emi, vld;
    in_valid = send_en && (pend.size() > 0);
    if (in_valid) {in_data, in_ctrl} = pend[0];
    else begin
      in_data = $urandom;
      in_ctrl = 16'($urandom);
    end
    @(negedge cpu_clk);
    check_outputs(ph);
    vld = (mq.size() > 0);
    acc = in_valid && exp_ready();
    emi = vld && out_ready;
    @(posedge cpu_clk);
    if (clr_cnt) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (vld && !out_ready && m_stall < cnt_max) m_stall++;
      if (!vld && m_bubble < cnt_max) m_bubble++;
    end
    if (flush) mq.delete();
    else begin
      if (emi) void'(mq.pop_front());
      if (acc) mq.push_back({in_data, in_ctrl});
    end
    if (acc) void'(pend.pop_front());
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b0; send_en = 1'b0;
    in_data = '0; in_ctrl = '0;
    mq.delete(); pend.delete();
    m_stall = 0; m_bubble = 0;
    repeat (2) begin
      @(negedge cpu_clk);
      check_outputs("reset");
    end
    @(posedge cpu_clk);
    #1 reset = 1'b0;
  endtask

  task automatic random_phase(string ph, int n);
    for (int i = 0; i < n; i++) begin
      if (pend.size() < 4) pend.push_back({$urandom, 16'($urandom)});
      send_en   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      cycle(ph);
    end
    flush = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    // ---------------- skid build, 4-bit counters ----------------
    sel = 1'b0; m_skid = 1'b1; cnt_max = 15;
    do_reset();

    for (int i = 1; i <= 4; i++) pend.push_back({32'(i), 16'hA5A5});
    send_en = 1'b1; out_ready = 1'b1;
    repeat (7) cycle("stream");

    out_ready = 1'b0;
    pend.push_back({32'h11, 16'h0011});
    pend.push_back({32'h22, 16'h0022});
    pend.push_back({32'h33, 16'h0033});
    repeat (5) cycle("backpressure");
    chk("held_upstream", 64'(in_valid & ~o_rdy), 64'd1);
    out_ready = 1'b1;
    repeat (6) cycle("release");

    out_ready = 1'b0;
    pend.push_back({32'h55, 16'h0055});
    pend.push_back({32'h66, 16'h0066});
    repeat (2) cycle("fill");
    pend.push_back({32'h44, 16'h0044});
    flush = 1'b1;
    cycle("flush_skid");
    flush = 1'b0; pend.delete(); out_ready = 1'b1;
    cycle("post_flush");

    out_ready = 1'b0;
    pend.push_back({32'h45, 16'h0045});
    cycle("fill_one");
    pend.push_back({32'h46, 16'h0046});
    flush = 1'b1;
    cycle("flush_accept");
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) cycle("post_flush2");

    out_ready = 1'b0;
    pend.push_back({32'h88, 16'h0088});
    pend.push_back({32'h99, 16'h0099});
    repeat (3) cycle("fill_async");
    #2 reset = 1'b1;
    #1;
    mq.delete(); pend.delete(); m_stall = 0; m_bubble = 0;
    check_outputs("async_reset");
    @(posedge cpu_clk);
    #1 reset = 1'b0;
    pend.push_back({32'h77, 16'h0077});
    send_en = 1'b1; out_ready = 1'b1;
    repeat (4) cycle("after_reset");

    send_en = 1'b0;
    repeat (20) cycle("idle");
    chk("bubble_sat", 64'(o_bubble), 64'd15);
    clr_cnt = 1'b1;
    cycle("clr");
    clr_cnt = 1'b0;
    chk("bubble_clr", 64'(o_bubble), 64'd0);
    repeat (3) cycle("recount");

    random_phase("rand_skid", 300);

    // ---------------- pass build, combinational ready ----------------
    do_reset();
    sel = 1'b1; m_skid = 1'b0; cnt_max = 65535;
    do_reset();
    for (int i = 1; i <= 8; i++) pend.push_back({32'(i * 32'h101), 16'(i)});
    send_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2 == 0);
      cycle("toggle");
    end
    random_phase("rand_pass", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
